// File: rtl/mc_control_fsm.sv
// Multi-cycle control sequencer for the 16-bit CPU: fetch/decode/execute/memory/writeback,
// with PC controls, memory handshake, datapath enables and a retired-instruction counter.
module mc_control_fsm #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [15:0]      instr,
  input  logic             zero,
  input  logic             mem_ack,
  input  logic             resume,
  output logic             mem_req,
  output logic             mem_we,
  output logic             ir_load,
  output logic             inc_PC,
  output logic             pc_src,
  output logic             halt,
  output logic             reg_we,
  output logic [2:0]       alu_op,
  output logic             alu_src_imm,
  output logic             wb_sel,
  output logic             illegal,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [2:0] {
    StFetch  = 3'd0,
    StDecode = 3'd1,
    StExec   = 3'd2,
    StMem    = 3'd3,
    StWb     = 3'd4,
    StHalt   = 3'd7
  } state_e;

  typedef enum logic [3:0] {
    OpNop  = 4'h0,
    OpAdd  = 4'h1,
    OpSub  = 4'h2,
    OpAnd  = 4'h3,
    OpOr   = 4'h4,
    OpXor  = 4'h5,
    OpAddi = 4'h6,
    OpLd   = 4'h7,
    OpSt   = 4'h8,
    OpBeq  = 4'h9,
    OpBne  = 4'hA,
    OpJmp  = 4'hB,
    OpIllC = 4'hC,
    OpIllD = 4'hD,
    OpIllE = 4'hE,
    OpHlt  = 4'hF
  } opcode_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] retired_q;
  logic             illegal_q;
  logic             retire;
  logic             set_illegal;
  opcode_e          op;

  assign op = opcode_e'(instr[15:12]);

  // Operand/immediate fields are consumed by the datapath, not here.
  logic unused_instr;
  assign unused_instr = ^instr[11:0];

  always_comb begin
    state_d     = state_q;
    retire      = 1'b0;
    set_illegal = 1'b0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    ir_load     = 1'b0;
    inc_PC      = 1'b0;
    pc_src      = 1'b0;
    halt        = 1'b0;
    reg_we      = 1'b0;
    alu_op      = 3'd0;
    alu_src_imm = 1'b0;
    wb_sel      = 1'b0;

    case (state_q)
      StFetch: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          ir_load = 1'b1;
          inc_PC  = 1'b1;
          state_d = StDecode;
        end
      end
      StDecode: state_d = StExec;
      StExec: begin
        case (op)
          OpAdd, OpSub, OpAnd, OpOr, OpXor: begin
            alu_op  = instr[14:12] - 3'd1;
            state_d = StWb;
          end
          OpAddi: begin
            alu_src_imm = 1'b1;
            state_d     = StWb;
          end
          // Effective address is rs + imm through the ALU.
          OpLd, OpSt: begin
            alu_src_imm = 1'b1;
            state_d     = StMem;
          end
          OpBeq: begin
            alu_op  = 3'd1;
            pc_src  = zero;
            state_d = StFetch;
            retire  = 1'b1;
          end
          OpBne: begin
            alu_op  = 3'd1;
            pc_src  = ~zero;
            state_d = StFetch;
            retire  = 1'b1;
          end
          OpJmp: begin
            pc_src  = 1'b1;
            state_d = StFetch;
            retire  = 1'b1;
          end
          OpNop: begin
            state_d = StFetch;
            retire  = 1'b1;
          end
          OpHlt: begin
            state_d = StHalt;
            retire  = 1'b1;
          end
          default: begin
            set_illegal = 1'b1;
            state_d     = StHalt;
          end
        endcase
      end
      StMem: begin
        mem_req = 1'b1;
        mem_we  = (op == OpSt);
        if (mem_ack) begin
          if (op == OpSt) begin
            state_d = StFetch;
            retire  = 1'b1;
          end else begin
            state_d = StWb;
          end
        end
      end
      StWb: begin
        reg_we  = 1'b1;
        wb_sel  = (op == OpLd);
        state_d = StFetch;
        retire  = 1'b1;
      end
      StHalt: begin
        halt = 1'b1;
        if (resume) state_d = StFetch;
      end
      default: state_d = StFetch;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StFetch;
      retired_q <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (retire)      retired_q <= retired_q + CNT_W'(1);
      if (set_illegal) illegal_q <= 1'b1;
    end
  end

  assign state   = state_q;
  assign retired = retired_q;
  assign illegal = illegal_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Table-driven bench for mc_control_fsm: per-cycle vectors of inputs and expected outputs,
// expected records queued when driven and compared just before the next rising edge.
module tb_mc_control_fsm;

  // Narrow counter so the wrap sequence stays short.
  localparam int unsigned CntW = 8;

  localparam logic [11:0] CReq = 12'h800;
  localparam logic [11:0] CWe  = 12'h400;
  localparam logic [11:0] CIrl = 12'h200;
  localparam logic [11:0] CInc = 12'h100;
  localparam logic [11:0] CPcs = 12'h080;
  localparam logic [11:0] CHlt = 12'h040;
  localparam logic [11:0] CRwe = 12'h020;
  localparam logic [11:0] CImm = 12'h002;
  localparam logic [11:0] CWbs = 12'h001;
  localparam logic [11:0] CFetchAck = CReq | CIrl | CInc;

  logic            clk;
  logic            reset;
  logic [15:0]     instr;
  logic            zero;
  logic            mem_ack;
  logic            resume;
  logic            mem_req;
  logic            mem_we;
  logic            ir_load;
  logic            inc_PC;
  logic            pc_src;
  logic            halt;
  logic            reg_we;
  logic [2:0]      alu_op;
  logic            alu_src_imm;
  logic            wb_sel;
  logic            illegal;
  logic [2:0]      state;
  logic [CntW-1:0] retired;

  mc_control_fsm #(.CNT_W(CntW)) dut (
    .clk         (clk),
    .reset       (reset),
    .instr       (instr),
    .zero        (zero),
    .mem_ack     (mem_ack),
    .resume      (resume),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .ir_load     (ir_load),
    .inc_PC      (inc_PC),
    .pc_src      (pc_src),
    .halt        (halt),
    .reg_we      (reg_we),
    .alu_op      (alu_op),
    .alu_src_imm (alu_src_imm),
    .wb_sel      (wb_sel),
    .illegal     (illegal),
    .state       (state),
    .retired     (retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0]     instr;
    logic            zero;
    logic            ack;
    logic            resume;
    logic            rst;
    logic [2:0]      st;
    logic [11:0]     ctl;
    logic [CntW-1:0] ret;
    logic            ill;
  } vec_t;

  vec_t            tbl[$];
  vec_t            sb[$];
  int              errors = 0;
  int              checks = 0;
  int              vec_no = 0;
  logic [CntW-1:0] r;
  logic            il;
  logic [15:0]     ins;

  function automatic logic [11:0] aop(input int n);
    return 12'(n) << 2;
  endfunction

  task automatic add(input logic [15:0] i, input logic z, input logic a, input logic rs,
                     input logic rt, input logic [2:0] st, input logic [11:0] c);
    vec_t v;
    v.instr = i; v.zero = z; v.ack = a; v.resume = rs; v.rst = rt;
    v.st = st; v.ctl = c; v.ret = r; v.ill = il;
    tbl.push_back(v);
  endtask

  // Zero-wait fetch then decode; ack/resume high in DECODE must be ignored.
  task automatic fd(input logic [15:0] i);
    add(i, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, CFetchAck);
    add(i, 1'b0, 1'b1, 1'b1, 1'b0, 3'd1, 12'h000);
  endtask

  task automatic br(input logic [15:0] i, input logic z, input logic [11:0] c);
    fd(i);
    add(i, z, 1'b1, 1'b0, 1'b0, 3'd2, c);
    r++;
  endtask

  task automatic drive(input vec_t v);
    @(negedge clk);
    instr   = v.instr;
    zero    = v.zero;
    mem_ack = v.ack;
    resume  = v.resume;
    reset   = v.rst;
    sb.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL vec%0d %s: got 0x%0h want 0x%0h", vec_no, name, got, want);
    end
  endtask

  initial begin
    vec_t e;
    forever begin
      @(negedge clk);
      #4;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("state", 32'(state), 32'(e.st));
        chk("ctl", 32'({mem_req, mem_we, ir_load, inc_PC, pc_src, halt, reg_we, alu_op,
                        alu_src_imm, wb_sel}), 32'(e.ctl));
        chk("retired", 32'(retired), 32'(e.ret));
        chk("illegal", 32'(illegal), 32'(e.ill));
        vec_no++;
      end
    end
  end

  initial begin
    reset = 1'b1; instr = 16'h0; zero = 1'b0; mem_ack = 1'b0; resume = 1'b0;
    r = '0; il = 1'b0;

    // Reset state, FETCH waiting on memory.
    add(16'h1234, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, CReq);
    add(16'h1234, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, CReq);
    // ALU ops 1..5 zero-wait: FETCH, DECODE, EXEC, WB.
    for (int op = 1; op <= 5; op++) begin
      ins = {op[3:0], 12'h234};
      fd(ins);
      add(ins, 1'b1, 1'b1, 1'b0, 1'b0, 3'd2, aop(op - 1));
      add(ins, 1'b0, 1'b1, 1'b0, 1'b0, 3'd4, CRwe);
      r++;
    end
    // ADDI
    fd(16'h6F05);
    add(16'h6F05, 1'b0, 1'b1, 1'b0, 1'b0, 3'd2, CImm);
    add(16'h6F05, 1'b0, 1'b1, 1'b0, 1'b0, 3'd4, CRwe);
    r++;
    // LD with 2 fetch waits and 3 memory waits: 10 cycles.
    ins = 16'h7010;
    repeat (2) add(ins, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, CReq);
    add(ins, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, CFetchAck);
    add(ins, 1'b0, 1'b1, 1'b1, 1'b0, 3'd1, 12'h000);
    add(ins, 1'b0, 1'b1, 1'b0, 1'b0, 3'd2, CImm);
    repeat (3) add(ins, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3, CReq);
    add(ins, 1'b0, 1'b1, 1'b0, 1'b0, 3'd3, CReq);
    add(ins, 1'b0, 1'b1, 1'b0, 1'b0, 3'd4, CRwe | CWbs);
    r++;
    // ST with one memory wait.
    ins = 16'h8010;
    fd(ins);
    add(ins, 1'b0, 1'b1, 1'b0, 1'b0, 3'd2, CImm);
    add(ins, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3, CReq | CWe);
    add(ins, 1'b0, 1'b1, 1'b0, 1'b0, 3'd3, CReq | CWe);
    r++;
    // Branches, JMP, NOP.
    br(16'h900A, 1'b1, aop(1) | CPcs);
    br(16'h900A, 1'b0, aop(1));
    br(16'hA00A, 1'b0, aop(1) | CPcs);
    br(16'hA00A, 1'b1, aop(1));
    br(16'hB00A, 1'b0, CPcs);
    br(16'hB00A, 1'b1, CPcs);
    br(16'h0000, 1'b1, 12'h000);
    // HLT: counted on entry, held 5 cycles, then resume.
    fd(16'hF000);
    add(16'hF000, 1'b0, 1'b1, 1'b0, 1'b0, 3'd2, 12'h000);
    r++;
    repeat (5) add(16'hF000, 1'b0, 1'b1, 1'b0, 1'b0, 3'd7, CHlt);
    add(16'hF000, 1'b0, 1'b0, 1'b1, 1'b0, 3'd7, CHlt);
    // Illegal opcodes: sticky flag, HALT, not counted.
    fd(16'hC000);
    add(16'hC000, 1'b0, 1'b1, 1'b0, 1'b0, 3'd2, 12'h000);
    il = 1'b1;
    repeat (2) add(16'hC000, 1'b0, 1'b1, 1'b0, 1'b0, 3'd7, CHlt);
    add(16'hC000, 1'b0, 1'b0, 1'b1, 1'b0, 3'd7, CHlt);
    fd(16'hE123);
    add(16'hE123, 1'b1, 1'b1, 1'b0, 1'b0, 3'd2, 12'h000);
    add(16'hE123, 1'b0, 1'b0, 1'b1, 1'b0, 3'd7, CHlt);
    br(16'h0000, 1'b0, 12'h000);
    // Reset mid-MEM of an LD, with ack arriving in the reset cycle.
    ins = 16'h7000;
    fd(ins);
    add(ins, 1'b0, 1'b1, 1'b0, 1'b0, 3'd2, CImm);
    add(ins, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3, CReq);
    add(ins, 1'b0, 1'b1, 1'b0, 1'b1, 3'd3, CReq);
    r = '0; il = 1'b0;
    add(ins, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, CReq);

    repeat (2) @(negedge clk);
    foreach (tbl[k]) drive(tbl[k]);

    // Counter wrap: 2**CntW + 1 NOPs, checked every cycle.
    for (int k = 0; k <= (1 << CntW); k++) begin
      vec_t v;
      v.instr = 16'h0000; v.zero = k[0]; v.ack = 1'b1; v.resume = 1'b0; v.rst = 1'b0;
      v.ill = 1'b0; v.ret = r;
      v.st = 3'd0; v.ctl = CFetchAck; drive(v);
      v.st = 3'd1; v.ctl = 12'h000;   drive(v);
      v.st = 3'd2;                    drive(v);
      r++;
    end
    // Follow-up fetch shows the wrapped count (2**CntW + 1 retirements).
    begin
      vec_t v;
      v.instr = 16'h0000; v.zero = 1'b0; v.ack = 1'b0; v.resume = 1'b0; v.rst = 1'b0;
      v.ill = 1'b0; v.ret = CntW'(1); v.st = 3'd0; v.ctl = CReq;
      drive(v);
    end

    repeat (2) @(negedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mc_control_fsm.md
# mc_control_fsm

Multi-cycle sequencer for the 16-bit CPU. It steps each instruction through fetch, decode, execute, memory and writeback. Along the way it drives the program counter's `inc_PC`, `pc_src` and `halt` controls, handshakes with the shared instruction/data memory, and raises datapath enables. It sits between the IR/flag outputs of the datapath and the PC, register file, ALU and memory port.

## Interface
Parameters:
- `CNT_W`, 16, width of the retired-instruction counter

Ports:
- `clk`  in  1  system clock, rising edge
- `reset`  in  1  synchronous, active-high
- `instr`  in  16  current IR contents; opcode = `instr[15:12]`
- `zero`  in  1  ALU zero flag, valid in EXEC
- `mem_ack`  in  1  memory completion, sampled while `mem_req`=1
- `resume`  in  1  leave HALT state
- `mem_req`  out  1  memory access request
- `mem_we`  out  1  write strobe, qualified by `mem_req`
- `ir_load`  out  1  latch memory read data into IR
- `inc_PC`  out  1  PC increment, one-cycle pulse
- `pc_src`  out  1  PC loads `next_addr` (= `instr[7:0]`, muxed by datapath)
- `halt`  out  1  freeze PC
- `reg_we`  out  1  register-file write enable
- `alu_op`  out  3  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR
- `alu_src_imm`  out  1  ALU B operand = sign-extended `instr[7:0]`
- `wb_sel`  out  1  0 = ALU result, 1 = memory data
- `illegal`  out  1  sticky, undefined opcode seen
- `state`  out  3  FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=7
- `retired`  out  CNT_W  instructions completed

## Operation
- Opcodes:
  - 0 NOP; 1 ADD; 2 SUB; 3 AND; 4 OR; 5 XOR; 6 ADDI; 7 LD; 8 ST; 9 BEQ; A BNE; B JMP; F HLT.
  - C, D and E are illegal.
- FETCH:
  - `mem_req`=1, `mem_we`=0.
  - Stays in FETCH while `mem_ack`=0.
  - In the cycle `mem_ack`=1: `ir_load`=1 and `inc_PC`=1, then go to DECODE.
- DECODE: no outputs asserted; go to EXEC.
- EXEC, by opcode:
  - ALU ops 1–5 (op−1 → `alu_op`): go to WB.
  - ADDI: `alu_op`=0, `alu_src_imm`=1; go to WB.
  - LD / ST: go to MEM. Address = ALU(rs + imm), so `alu_src_imm`=1 and `alu_op`=0.
  - BEQ: `alu_op`=1; `pc_src`=`zero`.
  - BNE: `alu_op`=1; `pc_src`=~`zero`.
  - JMP: `pc_src`=1.
  - BEQ, BNE, JMP and NOP go to FETCH.
  - HLT: go to HALT.
  - Illegal: set `illegal`, go to HALT.
- MEM:
  - `mem_req`=1; `mem_we`=1 for ST only.
  - Waits for `mem_ack`.
  - On ack: LD goes to WB; ST goes to FETCH.
- WB:
  - `reg_we`=1 for one cycle.
  - `wb_sel`=1 for LD, 0 otherwise.
  - Go to FETCH.
- HALT:
  - `halt`=1 continuously.
  - `resume`=1 → FETCH.
  - Nothing else leaves HALT except `reset`.
- `retired` increments by 1 on every transition into FETCH from EXEC/MEM/WB, and on entry to HALT via HLT.
  - Illegal opcodes are not counted.
  - Wraps from all-ones to 0.
- Control outputs are combinational from `state`, `instr`, `zero` and `mem_ack`. Outside the listed cases they are 0.

## Timing
- Reset:
  - Any state → FETCH on the next edge.
  - `retired`=0, `illegal`=0.
  - Reset has priority over `mem_ack`, `resume` and an in-flight access; the access is abandoned.
- Reset values, while in FETCH after reset with `mem_ack`=0:
  - `mem_req`=1.
  - `state`=0, `retired`=0, `illegal`=0.
  - All other outputs are 0.
- Cycle counts with zero-wait memory (ack in the same cycle as req):
  - ALU/ADDI: 4 cycles.
  - LD: 5 cycles.
  - ST: 4 cycles.
  - Branch, JMP, NOP: 3 cycles.
- Each memory wait cycle adds 1 to the FETCH or MEM phase.
- `inc_PC` and `pc_src` are never asserted in the same cycle.
- Both are 0 whenever `halt`=1.
- Branch target is taken on the EXEC edge. The PC has already been incremented in FETCH.
- `mem_ack` outside FETCH/MEM is ignored.
- `resume` outside HALT is ignored.

## Test plan
- Reset:
  - Assert `reset` mid-MEM of an LD with `mem_ack`=0, release.
  - Required: `state`=0, `retired`=0, `illegal`=0, `mem_req`=1, `inc_PC`/`pc_src`/`reg_we`/`halt`=0.
- ADD, zero-wait:
  - `instr`=0x1xxx with `mem_ack` tied 1.
  - Required: state sequence 0,1,2,4,0.
  - Required: `inc_PC`=1 only in cycle 1.
  - Required: `reg_we`=1 in the WB cycle with `alu_op`=0 and `wb_sel`=0.
  - Required: `retired` 0→1.
- LD with wait:
  - `instr`=0x7xxx; `mem_ack` low 2 cycles in FETCH and 3 cycles in MEM.
  - Required: 10 cycles total.
  - Required: `mem_req` held high throughout each wait.
  - Required: `wb_sel`=1 and `reg_we`=1 in WB.
- Branches:
  - BEQ 0x900A with `zero`=1 → `pc_src`=1 in EXEC, then back to FETCH.
  - BEQ with `zero`=0 → `pc_src`=0.
  - BNE with `zero`=0 → `pc_src`=1.
  - JMP → `pc_src`=1 regardless of `zero`.
- Halt/resume:
  - HLT 0xF000 → `state`=7 and `halt`=1 held for 5 cycles, `retired` increments.
  - `resume` pulse → FETCH next cycle, `halt`=0.
  - Illegal 0xC000 → `illegal`=1, `state`=7, `retired` unchanged.
- Counter wrap:
  - Run 65536 NOPs.
  - Required: `retired` wraps 0xFFFF→0x0000 with no glitch in control outputs.
